// File: rtl/simd_product_accumulator_if.sv
// Handshake bundle for simd_product_accumulator: product beats in, per-lane sums out.
// The master modport is the producer/consumer side; the slave modport is the accumulator.
interface simd_product_accumulator_if #(
    parameter int LANES  = 4,
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*PROD_W-1:0]  in_prod;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic [LANES*ACC_W-1:0]   out_acc;
    logic [7:0]               out_count;
    logic [LANES-1:0]         out_ovf;

    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_acc, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_acc, out_count, out_ovf
    );
endinterface

// File: rtl/simd_product_accumulator.sv
// Per-lane running sum of SIMD products, held until the consumer takes it.
// Define SIMD_ACC_SAT_EN to clamp overflowing lanes instead of wrapping them.
module simd_product_accumulator #(
    parameter int LANES  = 4,
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic                    CLK,
    input  logic                    nrst,
    simd_product_accumulator_if.slave bus
);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [LANES*ACC_W-1:0]   acc_q, acc_d;
    logic [7:0]               count_q, count_d;
    logic [LANES-1:0]         ovf_q, ovf_d;
    logic [ACC_W:0]           lane_sum_s [LANES];
    logic                     accept_s;

    assign accept_s      = bus.in_valid && (state_q == ST_ACC);
    assign bus.in_ready  = (state_q == ST_ACC) && nrst;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_acc   = acc_q;
    assign bus.out_count = count_q;
    assign bus.out_ovf   = ovf_q;

    // Per-lane sum with one carry bit, which is the overflow indicator.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_sum_s[i] = {1'b0, acc_q[i*ACC_W +: ACC_W]}
                          + {{(ACC_W-PROD_W+1){1'b0}}, bus.in_prod[i*PROD_W +: PROD_W]};
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_ACC: begin
                if (accept_s) begin
                    for (int i = 0; i < LANES; i++) begin
                        ovf_d[i] = ovf_q[i] | lane_sum_s[i][ACC_W];
`ifdef SIMD_ACC_SAT_EN
                        // Once a lane has overflowed it stays pinned at full scale.
                        acc_d[i*ACC_W +: ACC_W] = ovf_d[i] ? {ACC_W{1'b1}}
                                                           : lane_sum_s[i][ACC_W-1:0];
`else
                        acc_d[i*ACC_W +: ACC_W] = lane_sum_s[i][ACC_W-1:0];
`endif
                    end
                    count_d = (count_q == 8'd255) ? 8'd255 : count_q + 8'd1;
                    if (bus.in_last) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ACC;
                    end
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    acc_d   = '0;
                    count_d = 8'd0;
                    ovf_d   = '0;
                    state_d = ST_ACC;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!nrst) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            count_q <= 8'd0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_simd_product_accumulator.sv
// Directed self-checking bench for simd_product_accumulator (default parameters).
module tb_simd_product_accumulator;

    logic CLK;
    logic nrst;
    int   checks;
    int   failures;

    simd_product_accumulator_if bus ();

    simd_product_accumulator dut (
        .CLK  (CLK),
        .nrst (nrst),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Zero-extend each 8-bit lane product into a 16-bit lane.
    function automatic logic [63:0] widen(input logic [31:0] p);
        logic [63:0] r;
        for (int i = 0; i < 4; i++) r[i*16 +: 16] = {8'h00, p[i*8 +: 8]};
        return r;
    endfunction

    task automatic send_beat(input logic [31:0] prod, input logic last);
        bus.in_valid = 1'b1;
        bus.in_prod  = prod;
        bus.in_last  = last;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    logic [31:0] p_s;
    logic [31:0] b2b [4];
    logic [63:0] ovf_exp;

    initial begin
        checks = 0;
        failures = 0;
        nrst = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_prod = 32'h0;
        bus.in_last = 1'b0;
        bus.out_ready = 1'b0;
        p_s = {8'h00, 8'h36, 8'h96, 8'hE1};
        b2b[0] = 32'h01020304;
        b2b[1] = 32'hFF00E100;
        b2b[2] = 32'h00000036;
        b2b[3] = 32'h80402010;

        tick();
        tick();
        check("reset_in_ready", {63'd0, bus.in_ready}, 64'd0);
        check("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("reset_acc", bus.out_acc, 64'd0);
        check("reset_count", {56'd0, bus.out_count}, 64'd0);
        check("reset_ovf", {60'd0, bus.out_ovf}, 64'd0);
        nrst = 1'b1;
        #1;
        check("post_reset_in_ready", {63'd0, bus.in_ready}, 64'd1);

        // Single beat
        send_beat(p_s, 1'b1);
        check("single_valid", {63'd0, bus.out_valid}, 64'd1);
        check("single_acc", bus.out_acc, 64'h0000_0036_0096_00E1);
        check("single_count", {56'd0, bus.out_count}, 64'd1);
        check("single_ovf", {60'd0, bus.out_ovf}, 64'd0);
        release_result();
        check("single_rel_valid", {63'd0, bus.out_valid}, 64'd0);
        check("single_rel_acc_clear", bus.out_acc, 64'd0);

        // Three beats
        send_beat(p_s, 1'b0);
        send_beat(p_s, 1'b0);
        check("three_mid_valid", {63'd0, bus.out_valid}, 64'd0);
        send_beat(p_s, 1'b1);
        check("three_valid", {63'd0, bus.out_valid}, 64'd1);
        check("three_acc", bus.out_acc, 64'h0000_00A2_01C2_02A3);
        check("three_count", {56'd0, bus.out_count}, 64'd3);
        check("three_in_ready", {63'd0, bus.in_ready}, 64'd0);

        // Backpressure with ignored upstream beats
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            bus.in_prod  = 32'hFFFF_FFFF;
            bus.in_last  = 1'b1;
            tick();
            check("bp_acc", bus.out_acc, 64'h0000_00A2_01C2_02A3);
            check("bp_count", {56'd0, bus.out_count}, 64'd3);
            check("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
            check("bp_valid", {63'd0, bus.out_valid}, 64'd1);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        release_result();
        check("bp_rel_valid", {63'd0, bus.out_valid}, 64'd0);
        check("bp_rel_in_ready", {63'd0, bus.in_ready}, 64'd1);
        send_beat(32'h0000_0036, 1'b1);
        check("bp_next_acc", bus.out_acc, 64'h0000_0000_0000_0036);
        check("bp_next_count", {56'd0, bus.out_count}, 64'd1);
        release_result();

        // Overflow: 292 * 0xE1 = 65700
        for (int k = 0; k < 291; k++) send_beat(32'h0000_00E1, 1'b0);
        send_beat(32'h0000_00E1, 1'b1);
`ifdef SIMD_ACC_SAT_EN
        ovf_exp = 64'h0000_0000_0000_FFFF;
`else
        ovf_exp = 64'h0000_0000_0000_00A4;
`endif
        check("ovf_valid", {63'd0, bus.out_valid}, 64'd1);
        check("ovf_count", {56'd0, bus.out_count}, 64'd255);
        check("ovf_flags", {60'd0, bus.out_ovf}, 64'h1);
        check("ovf_acc", bus.out_acc, ovf_exp);
        release_result();
        check("ovf_rel_flags", {60'd0, bus.out_ovf}, 64'h0);

        // Reset mid-packet
        send_beat(32'h0000_00E1, 1'b0);
        send_beat(32'h0000_00E1, 1'b0);
        nrst = 1'b0;
        #1;
        check("rst_mid_in_ready", {63'd0, bus.in_ready}, 64'd0);
        tick();
        check("rst_mid_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_mid_in_ready2", {63'd0, bus.in_ready}, 64'd0);
        nrst = 1'b1;
        #1;
        check("rst_mid_in_ready_back", {63'd0, bus.in_ready}, 64'd1);
        send_beat(32'h0000_0036, 1'b1);
        check("rst_mid_acc", bus.out_acc, 64'h0000_0000_0000_0036);
        check("rst_mid_count", {56'd0, bus.out_count}, 64'd1);
        release_result();

        // Back-to-back single-beat packets
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_last   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.in_prod = b2b[k];
            tick();
            check("b2b_valid", {63'd0, bus.out_valid}, 64'd1);
            check("b2b_acc", bus.out_acc, widen(b2b[k]));
            check("b2b_count", {56'd0, bus.out_count}, 64'd1);
            tick();
            check("b2b_gap_valid", {63'd0, bus.out_valid}, 64'd0);
            check("b2b_gap_in_ready", {63'd0, bus.in_ready}, 64'd1);
        end
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/simd_product_accumulator.md
# simd_product_accumulator

Downstream stage of the SIMD multiplier array. It consumes packed per-lane products, one beat per handshake, and keeps a running sum per lane until a beat marked last. It then presents the lane sums with a beat count and overflow flags, and holds them until the consumer accepts.

## Interface

- LANES, 4, number of SIMD lanes
- PROD_W, 8, width of one lane product (4x4 multiplier result)
- ACC_W, 16, width of one lane accumulator; must be >= PROD_W

- CLK  input  1  clock; all state updates on rising edge
- nrst  input  1  reset, synchronous, active-low
- in_valid  input  1  upstream beat valid
- in_ready  output  1  block can accept a beat
- in_prod  input  LANES*PROD_W  packed unsigned products; lane i at [i*PROD_W +: PROD_W]
- in_last  input  1  beat is the last of the packet
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_acc  output  LANES*ACC_W  packed lane sums; lane i at [i*ACC_W +: ACC_W]
- out_count  output  8  beats accumulated in the packet, saturating at 255
- out_ovf  output  LANES  per-lane overflow flag, sticky within the packet

## Operation

- Two states: ACC (accepting) and DONE (holding result).
- in_ready = 1 in ACC, 0 in DONE, and 0 in any cycle with nrst low.
- out_valid = 1 exactly in DONE.
- Accept in ACC: in_valid && in_ready.
  - acc[i] <= acc[i] + in_prod lane i, all operands unsigned.
  - count <= min(count+1, 255).
  - If in_last, go to DONE.
- Overflow: a lane's true sum exceeding 2^ACC_W-1 sets out_ovf[i]; see Configuration for the stored value.
- DONE with out_ready = 1: handshake. All acc, count and out_ovf clear to 0 and the state returns to ACC.
- DONE with out_ready = 0: all outputs stay stable. Upstream input is ignored.
- No accept and release in the same cycle. There is no bypass.
- in_valid without in_ready, and in_prod/in_last while in_valid = 0, are ignored.

## Timing

- Reset (nrst low at a rising edge): state = ACC, acc = 0, count = 0, out_ovf = 0, out_valid = 0. in_ready reads 1 from the first cycle with nrst high.
- Reset mid-packet discards the partial sums. Reset while in DONE drops the pending result.
- Accept throughput is 1 beat/cycle in ACC.
- out_valid rises in the cycle after the in_last beat is accepted (latency 1).
- After the output handshake edge, in_ready = 1 in the next cycle. The minimum packet period is 2 cycles for a 1-beat packet.
- A packet of N beats occupies N cycles in ACC plus at least 1 cycle in DONE.
- out_acc, out_count and out_ovf are registered. They are observable at all times and only meaningful while out_valid = 1.

## Configuration

- SIMD_ACC_SAT_EN defined: on overflow, the lane accumulator clamps to 2^ACC_W-1 and stays clamped for the rest of the packet.
- SIMD_ACC_SAT_EN undefined: the lane accumulator wraps modulo 2^ACC_W.
- out_ovf is set in both builds.

## Test plan

Defaults LANES=4, PROD_W=8, ACC_W=16. Lane 0 is listed first.

- Single beat: in_prod lanes {0xE1,0x96,0x36,0x00}, in_last=1 -> next cycle out_valid=1, out_acc lanes {0x00E1,0x0096,0x0036,0x0000}, out_count=1, out_ovf=0.
- Three beats, the same products each beat, last on beat 3 -> out_acc lanes {0x02A3,0x01C2,0x00A2,0x0000}, out_count=3. in_ready=0 while out_valid=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_acc and out_count stable, in_ready=0, extra in_valid beats ignored. Then pulse out_ready -> next cycle out_valid=0, in_ready=1, and a following 1-beat packet of 0x36 in lane 0 gives 0x0036.
- Overflow: 292 beats of 0xE1 in lane 0, others 0 -> out_count=255, out_ovf=4'b0001. Lane 0 reads 0xFFFF with SIMD_ACC_SAT_EN, or 0x00A4 without it.
- Reset mid-packet: accept 2 beats of 0xE1, then nrst low for 1 cycle -> out_valid=0, in_ready=0 during reset, then 1. A next 1-beat packet of 0x36 yields lane 0 = 0x0036, out_count=1.
- Back-to-back: in_valid held high with last on every beat, out_ready held high -> out_valid asserts in alternate cycles, and each result equals its single beat.
